// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv2d ReLU MAC datapath.
package conv_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR   = 2'b00,
        ACT_RELU     = 2'b01,
        ACT_LEAKY    = 2'b10,
        ACT_RELU_ALT = 2'b11
    } act_mode_t;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_FINAL,
        ST_OUT
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_act_sat.sv
// Combinational activation (linear / ReLU / leaky) and saturation from the
// accumulator width down to the output width.
module conv_act_sat
    import conv_pkg::*;
#(
    parameter int unsigned ACC_W = 21,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    input  act_mode_t               mode,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] y_full;

    always_comb begin
        y_full = acc;
        case (mode)
            ACT_LINEAR: y_full = acc;
            ACT_LEAKY: begin
                if (acc[ACC_W-1]) y_full = acc >>> 3;
            end
            default: begin
                if (acc[ACC_W-1]) y_full = '0;
            end
        endcase

        y   = y_full[OUT_W-1:0];
        sat = 1'b0;
        if (y_full > MAXV) begin
            y   = MAXV[OUT_W-1:0];
            sat = 1'b1;
        end else if (y_full < MINV) begin
            y   = MINV[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/conv2d_relu_mac.sv
// Streaming multiply-accumulate over one K*K*CH convolution window with bias,
// selectable activation and saturated output behind a valid/ready handshake.
module conv2d_relu_mac
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned CH     = 1,
    parameter int unsigned BIAS_W = 16,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_pixel,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic [1:0]               act_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int unsigned N      = K * K * CH;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = ((PROD_W > BIAS_W) ? PROD_W : BIAS_W) + clog2(N) + 1;
    localparam int unsigned CNT_W  = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    act_mode_t               mode_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [OUT_W-1:0]  act_y;
    logic                     act_sat;

    assign prod     = PROD_W'(in_pixel) * PROD_W'(in_weight);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};

    conv_act_sat #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_act_sat (
        .acc (acc),
        .mode(mode_q),
        .y   (act_y),
        .sat (act_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_ACC;
            cnt       <= '0;
            acc       <= '0;
            mode_q    <= ACT_RELU;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clr) begin
            // Abort wins over any transfer or handshake this cycle.
            state     <= ST_ACC;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        if (cnt == '0) begin
                            acc    <= prod_ext + bias_ext;
                            mode_q <= act_mode_t'(act_mode);
                        end else begin
                            acc <= acc + prod_ext;
                        end
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            state    <= ST_FINAL;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FINAL: begin
                    out_data  <= act_y;
                    out_sat   <= act_sat;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_relu_mac.sv
// Self-checking bench for conv2d_relu_mac: directed table, random windows
// against an arithmetic reference, and handshake/abort sequences.
module tb_conv2d_relu_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, clr, v1, v2, out_ready;
    logic signed [7:0] pix, wgt;
    logic signed [15:0] bias;
    logic [1:0]        mode;
    logic              r1, r2, ov1, ov2, s1, s2;
    logic signed [15:0] d1, d2;

    conv2d_relu_mac #(.DATA_W(8), .K(3), .CH(1), .BIAS_W(16), .OUT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(v1), .in_ready(r1),
        .in_pixel(pix), .in_weight(wgt), .bias(bias), .act_mode(mode),
        .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_sat(s1)
    );

    conv2d_relu_mac #(.DATA_W(8), .K(3), .CH(2), .BIAS_W(16), .OUT_W(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(v2), .in_ready(r2),
        .in_pixel(pix), .in_weight(wgt), .bias(bias), .act_mode(mode),
        .out_valid(ov2), .out_ready(out_ready), .out_data(d2), .out_sat(s2)
    );

    bit                 sel2;
    logic               ir, ov, os;
    logic signed [15:0] od;
    assign ir = sel2 ? r2 : r1;
    assign ov = sel2 ? ov2 : ov1;
    assign os = sel2 ? s2 : s1;
    assign od = sel2 ? d2 : d1;

    int px[18];
    int wt[18];
    int passed = 0;
    int total  = 0;

    typedef struct {
        int p; int w; int b; int m; bit ch2; int ey; int es;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model(input int n, input int b, input int m,
                                  output int y, output int sat);
        longint a;
        longint v;
        a = b;
        for (int i = 0; i < n; i++) a += longint'(px[i]) * longint'(wt[i]);
        v = a;
        if (a < 0) begin
            if (m == 2) v = -((-a + 7) / 8);
            else if (m != 0) v = 0;
        end
        sat = 0;
        y   = int'(v);
        if (v > 32767) begin y = 32767; sat = 1; end
        else if (v < -32768) begin y = -32768; sat = 1; end
    endfunction

    task automatic fill(input int p, input int w);
        for (int i = 0; i < 18; i++) begin px[i] = p; wt[i] = w; end
    endtask

    task automatic feed(input int n, input int b, input int m, input bit gaps);
        int w;
        w = 0;
        while (!ir && w < 20) begin @(negedge clk); w++; end
        check("ready_before_window", int'(ir), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            pix  = 8'(px[i]);
            wgt  = 8'(wt[i]);
            bias = 16'(b);
            mode = 2'(m);
            if (sel2) v2 = 1'b1; else v1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            v1   = 1'b0;
            v2   = 1'b0;
            // Only the first term's bias/mode should be used.
            bias = 16'($urandom);
            mode = 2'($urandom);
        end
    endtask

    task automatic collect(output int y, output int sat);
        int lat;
        lat = 0;
        check("no_valid_in_final", int'(ov), 0);
        while (!ov && lat < 10) begin @(negedge clk); lat++; end
        check("result_latency", lat, 1);
        y   = int'(od);
        sat = int'(os);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop_after_hs", int'(ov), 0);
        check("ready_after_hs", int'(ir), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int y, s, ey, es, n, b, m;

        reset_n = 1'b0; clr = 1'b0; v1 = 1'b0; v2 = 1'b0; out_ready = 1'b0;
        pix = '0; wgt = '0; bias = '0; mode = 2'b01; sel2 = 1'b0;

        tbl[0] = '{p: 1,    w: 2,   b: 0,  m: 1, ch2: 0, ey: 18,     es: 0};
        tbl[1] = '{p: 10,   w: -1,  b: 5,  m: 1, ch2: 0, ey: 0,      es: 0};
        tbl[2] = '{p: 10,   w: -1,  b: 5,  m: 2, ch2: 0, ey: -11,    es: 0};
        tbl[3] = '{p: 10,   w: -1,  b: 5,  m: 0, ch2: 0, ey: -85,    es: 0};
        tbl[4] = '{p: 127,  w: 127, b: 0,  m: 0, ch2: 1, ey: 32767,  es: 1};
        tbl[5] = '{p: -128, w: 127, b: 0,  m: 0, ch2: 1, ey: -32768, es: 1};
        tbl[6] = '{p: 10,   w: -1,  b: 5,  m: 3, ch2: 0, ey: 0,      es: 0};
        tbl[7] = '{p: -3,   w: 5,   b: -2, m: 2, ch2: 0, ey: -18,    es: 0};

        #12;
        check("reset_out_valid", int'(ov1), 0);
        check("reset_out_data", int'(d1), 0);
        check("reset_out_sat", int'(s1), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(r1), 1);

        for (int i = 0; i < 8; i++) begin
            sel2 = tbl[i].ch2;
            n = tbl[i].ch2 ? 18 : 9;
            fill(tbl[i].p, tbl[i].w);
            feed(n, tbl[i].b, tbl[i].m, 1'b0);
            collect(y, s);
            check($sformatf("table%0d_data", i), y, tbl[i].ey);
            check($sformatf("table%0d_sat", i), s, tbl[i].es);
            handshake();
        end
        sel2 = 1'b0;

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 9; i++) begin
                px[i] = int'($urandom_range(0, 255)) - 128;
                wt[i] = int'($urandom_range(0, 255)) - 128;
            end
            b = int'($urandom_range(0, 65535)) - 32768;
            m = int'($urandom_range(0, 3));
            model(9, b, m, ey, es);
            feed(9, b, m, 1'b1);
            collect(y, s);
            check($sformatf("rand%0d_data", t), y, ey);
            check($sformatf("rand%0d_sat", t), s, es);
            handshake();
        end

        // Backpressure, then a back-to-back window.
        fill(1, 2);
        feed(9, 0, 1, 1'b0);
        collect(y, s);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_data", int'(od), 18);
            check("stall_valid", int'(ov), 1);
            check("stall_in_ready", int'(ir), 0);
        end
        handshake();
        fill(10, -1);
        feed(9, 5, 0, 1'b0);
        collect(y, s);
        check("b2b_data", y, -85);
        handshake();

        // Reset after four terms discards the partial sum.
        fill(50, 50);
        feed(4, 100, 0, 1'b0);
        #1 reset_n = 1'b0;
        #1 check("midreset_valid", int'(ov1), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        fill(1, 2);
        feed(9, 0, 1, 1'b0);
        collect(y, s);
        check("after_reset_data", y, 18);
        handshake();

        // clr after four terms, with a term presented in the clr cycle.
        fill(50, 50);
        feed(4, 100, 0, 1'b0);
        clr = 1'b1; v1 = 1'b1; pix = 8'sd50; wgt = 8'sd50;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; v1 = 1'b0;
        check("clr_valid", int'(ov1), 0);
        check("clr_ready", int'(r1), 1);
        fill(1, 2);
        feed(9, 0, 1, 1'b0);
        collect(y, s);
        check("after_clr_data", y, 18);
        handshake();

        // clr while a result is pending overrides the handshake.
        feed(9, 0, 1, 1'b0);
        collect(y, s);
        clr = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; out_ready = 1'b0;
        check("clr_out_valid", int'(ov1), 0);
        check("clr_out_ready", int'(r1), 1);
        fill(-1, 2);
        feed(9, 0, 0, 1'b0);
        collect(y, s);
        check("after_clr_out_data", y, -18);
        handshake();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
